// File: rtl/bep_frame_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bep_frame_controller: decodes a pulse-width-coded line into 8-bit frames. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bep_frame_controller #(
  parameter int MIN_TIMING = 9,
  parameter int MAX_TIMING = 18,
  parameter int GLITCH_MAX = 2,
  parameter int LONG_LIMIT = 36,
  parameter int TIMEOUT    = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       digital_in,
  output logic [7:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       glitch_err,
  output logic       long_err,
  output logic       timeout_err,
  output logic       overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [7:0] MIN_W    = 8'(MIN_TIMING);
  localparam logic [7:0] MAX_W    = 8'(MAX_TIMING);
  localparam logic [7:0] GLITCH_W = 8'(GLITCH_MAX);
  localparam logic [7:0] LONG_W   = 8'(LONG_LIMIT);
  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] state_q, state_d;
  logic [7:0] width_q, width_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] count_q, count_d;
  logic [7:0] frame_data_q, frame_data_d;
  logic       frame_valid_q, frame_valid_d;
  logic       glitch_q, glitch_d;
  logic       long_q, long_d;
  logic       timeout_q, timeout_d;
  logic       overrun_q, overrun_d;
  logic       busy_c;
  logic       publish;

  logic       rise, fall;
  logic [7:0] diff_hi, diff_lo, gap_inc, frame_next;
  logic       bit_one;

  assign rise       = s2_q & ~s3_q;
  assign fall       = s3_q & ~s2_q;
  assign diff_hi    = (width_q >= MAX_W) ? (width_q - MAX_W) : (MAX_W - width_q);
  assign diff_lo    = (width_q >= MIN_W) ? (width_q - MIN_W) : (MIN_W - width_q);
  assign bit_one    = (diff_hi <= diff_lo);
  assign gap_inc    = gap_q + 8'd1;
  assign frame_next = {shreg_q[6:0], bit_one};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      state_q       <= ST_IDLE;
      width_q       <= 8'd0;
      gap_q         <= 8'd0;
      shreg_q       <= 8'd0;
      count_q       <= 4'd0;
      frame_data_q  <= 8'd0;
      frame_valid_q <= 1'b0;
      glitch_q      <= 1'b0;
      long_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      s1_q          <= digital_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      state_q       <= state_d;
      width_q       <= width_d;
      gap_q         <= gap_d;
      shreg_q       <= shreg_d;
      count_q       <= count_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      glitch_q      <= glitch_d;
      long_q        <= long_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    gap_d     = gap_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
    glitch_d  = 1'b0;
    long_d    = 1'b0;
    timeout_d = 1'b0;
    publish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          width_d = 8'd1;
        end
      end
      ST_HIGH: begin
        if (!fall) begin
          if (width_q != 8'hFF) width_d = width_q + 8'd1;
        end else if (width_q <= GLITCH_W) begin
          // A glitch is dropped without disturbing the gap already counted.
          glitch_d = 1'b1;
          state_d  = (count_q == 4'd0) ? ST_IDLE : ST_LOW;
        end else if (width_q > LONG_W) begin
          long_d  = 1'b1;
          shreg_d = 8'd0;
          count_d = 4'd0;
          state_d = ST_IDLE;
        end else begin
          shreg_d = frame_next;
          if (count_q == 4'd7) begin
            publish = 1'b1;
            count_d = 4'd0;
            state_d = ST_IDLE;
          end else begin
            count_d = count_q + 4'd1;
            gap_d   = 8'd0;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          width_d = 8'd1;
        end else if (gap_inc == GAP_LAST) begin
          timeout_d = 1'b1;
          shreg_d   = 8'd0;
          count_d   = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    if (publish) begin
      // An unaccepted frame is never overwritten; the newcomer is dropped.
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = frame_next;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy_c = (state_q == ST_HIGH) || (state_q == ST_LOW);
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_c;
  assign glitch_err  = glitch_q;
  assign long_err    = long_q;
  assign timeout_err = timeout_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire
